// File: rtl/target_collision_ctrl_if.sv
// Bus between the snake-head tracker, the target generator and the
// collision controller. STATE_DBG carries the controller's FSM state.
//
// Handshake: HEAD_STROBE is a valid-only strobe with no ready. A head
// position is consumed only on a cycle where HEAD_STROBE=1 and the
// controller is in ARMED. Strobes seen while BUSY=1 are dropped, not
// queued. TARGET_REACHED is a one-cycle request to the generator. The
// generator must present its new address on TARGET_ADDR_* by the second
// cycle after the pulse.
interface target_collision_ctrl_if;
  logic        HEAD_STROBE;
  logic [7:0]  HEAD_ADDR_H;
  logic [6:0]  HEAD_ADDR_V;
  logic [7:0]  TARGET_ADDR_H;
  logic [6:0]  TARGET_ADDR_V;
  logic        TARGET_REACHED;
  logic        GROW;
  logic [15:0] SCORE;
  logic        BUSY;
  logic [1:0]  STATE_DBG;

  modport slave (
    input  HEAD_STROBE, HEAD_ADDR_H, HEAD_ADDR_V, TARGET_ADDR_H, TARGET_ADDR_V,
    output TARGET_REACHED, GROW, SCORE, BUSY, STATE_DBG
  );

  modport master (
    output HEAD_STROBE, HEAD_ADDR_H, HEAD_ADDR_V, TARGET_ADDR_H, TARGET_ADDR_V,
    input  TARGET_REACHED, GROW, SCORE, BUSY, STATE_DBG
  );
endinterface

// File: rtl/target_collision_ctrl.sv
// Snake head / target collision controller. It detects a hit and asks the
// generator for a new target. It re-rolls the target when the new one lands
// on the head, up to MAX_REROLL times. It keeps a saturating 4-digit BCD
// score.
module target_collision_ctrl #(
  parameter int MAX_REROLL = 4
) (
  input logic                    CLK,
  input logic                    RESET,
  target_collision_ctrl_if.slave bus
);

  localparam logic [1:0] ST_ARMED  = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;

  localparam logic [3:0] MAX_CNT = 4'(MAX_REROLL);

  logic [1:0]  state;
  logic [3:0]  reroll_cnt;
  logic [7:0]  lat_h;
  logic [6:0]  lat_v;
  logic        tr_q;
  logic        grow_q;
  logic [15:0] score_q;
  logic [15:0] score_inc;
  logic        carry;
  logic [3:0]  dig;
  logic        hit;
  logic        on_head;

  // A hit is only recognised while armed; otherwise the strobe is dropped.
  assign hit = (state == ST_ARMED) && bus.HEAD_STROBE &&
               (bus.HEAD_ADDR_H == bus.TARGET_ADDR_H) &&
               (bus.HEAD_ADDR_V == bus.TARGET_ADDR_V);

  // The freshly generated target landed on the head that was just eaten.
  assign on_head = (bus.TARGET_ADDR_H == lat_h) && (bus.TARGET_ADDR_V == lat_v);

  // Decimal ripple increment of the score; it holds at 9999.
  always_comb begin
    score_inc = score_q;
    carry     = 1'b1;
    dig       = 4'd0;
    if (score_q != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        dig = score_q[i*4 +: 4];
        if (carry) begin
          if (dig == 4'd9) begin
            score_inc[i*4 +: 4] = 4'd0;
            carry               = 1'b1;
          end else begin
            score_inc[i*4 +: 4] = dig + 4'd1;
            carry               = 1'b0;
          end
        end
      end
    end
  end

  // Control FSM, output pulses, re-roll counter, latched head and score.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_ARMED;
      reroll_cnt <= 4'd0;
      lat_h      <= 8'd0;
      lat_v      <= 7'd0;
      tr_q       <= 1'b0;
      grow_q     <= 1'b0;
      score_q    <= 16'h0000;
    end else begin
      case (state)
        ST_ARMED: begin
          tr_q   <= 1'b0;
          grow_q <= 1'b0;
          if (hit) begin
            lat_h      <= bus.HEAD_ADDR_H;
            lat_v      <= bus.HEAD_ADDR_V;
            reroll_cnt <= 4'd0;
            tr_q       <= 1'b1;
            grow_q     <= 1'b1;
            score_q    <= score_inc;
            state      <= ST_SETTLE;
          end
        end
        // One-cycle wait so the generator's new address is valid in CHECK.
        ST_SETTLE: begin
          tr_q   <= 1'b0;
          grow_q <= 1'b0;
          state  <= ST_CHECK;
        end
        ST_CHECK: begin
          grow_q <= 1'b0;
          if (on_head && (reroll_cnt < MAX_CNT)) begin
            reroll_cnt <= reroll_cnt + 4'd1;
            tr_q       <= 1'b1;
            state      <= ST_SETTLE;
          end else begin
            tr_q  <= 1'b0;
            state <= ST_ARMED;
          end
        end
        default: begin
          tr_q   <= 1'b0;
          grow_q <= 1'b0;
          state  <= ST_ARMED;
        end
      endcase
    end
  end

  assign bus.TARGET_REACHED = tr_q;
  assign bus.GROW           = grow_q;
  assign bus.SCORE          = score_q;
  assign bus.BUSY           = (state != ST_ARMED);
  assign bus.STATE_DBG      = state;

endmodule

// File: tb/tb_target_collision_ctrl.sv
// Bench for target_collision_ctrl. The bench plays the head tracker and the
// target generator. A timeline reference model sits beside the DUT.
module tb_target_collision_ctrl;

  localparam int MAX_R = 4;

  logic CLK;
  logic RESET;
  target_collision_ctrl_if tcc_if ();

  target_collision_ctrl #(.MAX_REROLL(MAX_R)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (tcc_if)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- counters ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int tr_seen = 0;
  int grow_seen = 0;
  int busy_seen = 0;
  logic prev_tr = 1'b0;
  logic prev_grow = 1'b0;

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Timeline view. A hit opens an episode at offset 0. The generator is
  // asked for a target at every odd offset. The new target is judged at
  // every even offset. The episode closes at offset 2+2k, where k is the
  // number of re-rolls taken.
  bit        m_active;
  int        m_off;
  int        m_rerolls;
  int        m_score;
  bit [7:0]  m_lat_h;
  bit [6:0]  m_lat_v;
  bit        m_tr;
  bit        m_grow;

  function automatic logic [15:0] to_bcd(input int s);
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic model_edge(input bit rst, input bit stb, input bit [7:0] hh, input bit [6:0] hv,
                            input bit [7:0] th, input bit [6:0] tv);
    m_tr   = 1'b0;
    m_grow = 1'b0;
    if (rst) begin
      m_active  = 1'b0;
      m_off     = 0;
      m_rerolls = 0;
      m_score   = 0;
      m_lat_h   = '0;
      m_lat_v   = '0;
    end else if (!m_active) begin
      if (stb && hh == th && hv == tv) begin
        m_active  = 1'b1;
        m_off     = 1;
        m_rerolls = 0;
        m_lat_h   = hh;
        m_lat_v   = hv;
        m_score   = (m_score >= 9999) ? 9999 : m_score + 1;
        m_tr      = 1'b1;
        m_grow    = 1'b1;
      end
    end else if (m_off % 2 == 0) begin
      if (th == m_lat_h && tv == m_lat_v && m_rerolls < MAX_R) begin
        m_rerolls++;
        m_off++;
        m_tr = 1'b1;
      end else begin
        m_active = 1'b0;
      end
    end else begin
      m_off++;
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input bit rst, input bit stb, input bit [7:0] hh, input bit [6:0] hv,
                             input bit [7:0] th, input bit [6:0] tv);
    @(negedge CLK);
    RESET                = rst;
    tcc_if.HEAD_STROBE   = stb;
    tcc_if.HEAD_ADDR_H   = hh;
    tcc_if.HEAD_ADDR_V   = hv;
    tcc_if.TARGET_ADDR_H = th;
    tcc_if.TARGET_ADDR_V = tv;
    @(posedge CLK);
    model_edge(rst, stb, hh, hv, th, tv);
    #1;
    check_eq("target_reached", 16'(tcc_if.TARGET_REACHED), 16'(m_tr));
    check_eq("grow", 16'(tcc_if.GROW), 16'(m_grow));
    check_eq("busy", 16'(tcc_if.BUSY), 16'(m_active));
    check_eq("score", tcc_if.SCORE, to_bcd(m_score));
    check_eq("tr_spacing", 16'(tcc_if.TARGET_REACHED & prev_tr), 16'h0);
    check_eq("grow_spacing", 16'(tcc_if.GROW & prev_grow), 16'h0);
    prev_tr   = tcc_if.TARGET_REACHED;
    prev_grow = tcc_if.GROW;
    if (tcc_if.TARGET_REACHED) tr_seen++;
    if (tcc_if.GROW) grow_seen++;
    if (tcc_if.BUSY) busy_seen++;
  endtask

  task automatic idle(input int n, input bit [7:0] th, input bit [6:0] tv);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 8'd0, 7'd0, th, tv);
  endtask

  task automatic clear_seen();
    tr_seen = 0;
    grow_seen = 0;
    busy_seen = 0;
  endtask

  // A plain hit at (50,50) with no re-roll: three cycles in total.
  task automatic fast_hit();
    drive_cycle(1'b0, 1'b1, 8'd50, 7'd50, 8'd50, 7'd50);
    idle(2, 8'd1, 7'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RESET = 1'b1;
    tcc_if.HEAD_STROBE = 1'b0;
    tcc_if.HEAD_ADDR_H = '0;
    tcc_if.HEAD_ADDR_V = '0;
    tcc_if.TARGET_ADDR_H = '0;
    tcc_if.TARGET_ADDR_V = '0;

    // Reset state.
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 8'd0, 7'd0, 8'd80, 7'd60);
    check_eq("reset_score", tcc_if.SCORE, 16'h0000);
    check_eq("reset_busy", 16'(tcc_if.BUSY), 16'h0);

    // Single hit, issued on the first cycle after reset.
    clear_seen();
    drive_cycle(1'b0, 1'b1, 8'd80, 7'd60, 8'd80, 7'd60);
    idle(4, 8'd10, 7'd10);
    check_eq("hit_tr_count", 16'(tr_seen), 16'd1);
    check_eq("hit_grow_count", 16'(grow_seen), 16'd1);
    check_eq("hit_busy_cycles", 16'(busy_seen), 16'd2);
    check_eq("hit_score", tcc_if.SCORE, 16'h0001);

    // Near miss on the vertical coordinate.
    clear_seen();
    drive_cycle(1'b0, 1'b1, 8'd80, 7'd59, 8'd80, 7'd60);
    idle(3, 8'd80, 7'd60);
    check_eq("miss_tr_count", 16'(tr_seen), 16'd0);
    check_eq("miss_busy_cycles", 16'(busy_seen), 16'd0);
    check_eq("miss_score", tcc_if.SCORE, 16'h0001);

    // The target lands on the head twice, then moves away.
    clear_seen();
    drive_cycle(1'b0, 1'b1, 8'd20, 7'd30, 8'd20, 7'd30);
    idle(4, 8'd20, 7'd30);
    idle(4, 8'd10, 7'd10);
    check_eq("reroll2_tr_count", 16'(tr_seen), 16'd3);
    check_eq("reroll2_grow_count", 16'(grow_seen), 16'd1);
    check_eq("reroll2_score", tcc_if.SCORE, 16'h0002);

    // The generator keeps returning the head position: re-roll limit.
    clear_seen();
    drive_cycle(1'b0, 1'b1, 8'd20, 7'd30, 8'd20, 7'd30);
    idle(16, 8'd20, 7'd30);
    check_eq("limit_tr_count", 16'(tr_seen), 16'(MAX_R + 1));
    check_eq("limit_busy_end", 16'(tcc_if.BUSY), 16'h0);

    // Strobes during SETTLE and CHECK are ignored. The latched head stays
    // (7,7), so the target at (5,5) in CHECK must not re-roll.
    clear_seen();
    drive_cycle(1'b0, 1'b1, 8'd7, 7'd7, 8'd7, 7'd7);
    drive_cycle(1'b0, 1'b1, 8'd5, 7'd5, 8'd5, 7'd5);
    drive_cycle(1'b0, 1'b1, 8'd5, 7'd5, 8'd5, 7'd5);
    idle(3, 8'd9, 7'd9);
    check_eq("busy_strobe_tr_count", 16'(tr_seen), 16'd1);

    // Reset while in SETTLE abandons the re-roll.
    clear_seen();
    drive_cycle(1'b0, 1'b1, 8'd33, 7'd44, 8'd33, 7'd44);
    drive_cycle(1'b1, 1'b0, 8'd0, 7'd0, 8'd33, 7'd44);
    check_eq("rst_mid_state", 16'(tcc_if.STATE_DBG), 16'h0);
    idle(4, 8'd33, 7'd44);
    check_eq("rst_mid_tr_count", 16'(tr_seen), 16'd1);
    check_eq("rst_mid_score", tcc_if.SCORE, 16'h0000);

    // Randomised traffic on a small coordinate grid, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      bit [7:0] hh, th;
      bit [6:0] hv, tv;
      bit rst;
      rst = ($urandom_range(0, 99) == 0);
      hh = 8'($urandom_range(0, 2));
      hv = 7'($urandom_range(0, 2));
      if (m_active && $urandom_range(0, 1) == 1) begin
        th = m_lat_h;
        tv = m_lat_v;
      end else if ($urandom_range(0, 2) == 0) begin
        th = hh;
        tv = hv;
      end else begin
        th = 8'($urandom_range(0, 2));
        tv = 7'($urandom_range(0, 2));
      end
      drive_cycle(rst, 1'($urandom_range(0, 1)), hh, hv, th, tv);
    end

    // Decimal carry and saturation.
    drive_cycle(1'b1, 1'b0, 8'd0, 7'd0, 8'd1, 7'd1);
    for (int i = 0; i < 99; i++) fast_hit();
    check_eq("score_0099", tcc_if.SCORE, 16'h0099);
    fast_hit();
    check_eq("score_0100", tcc_if.SCORE, 16'h0100);
    for (int i = 0; i < 9899; i++) fast_hit();
    check_eq("score_9999", tcc_if.SCORE, 16'h9999);
    clear_seen();
    fast_hit();
    check_eq("sat_score", tcc_if.SCORE, 16'h9999);
    check_eq("sat_grow_count", 16'(grow_seen), 16'd1);
    check_eq("sat_tr_count", 16'(tr_seen), 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
